// File: rtl/entropy_pkg.sv
// rtl/entropy_pkg.sv - Shared types and constants for the entropy byte transmit path.
package entropy_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  // Cycles to wait for the UART busy flag before assuming the start was missed.
  localparam int BUSY_GUARD = 2;

endpackage

// File: rtl/byte_fifo_2w1r.sv
// rtl/byte_fifo_2w1r.sv - Byte FIFO with two write lanes, one read port and a registered head.
module byte_fifo_2w1r #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data0,
  input  logic [7:0]             wr_data1,
  input  logic                   rd_en,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, wr_ptr_1, rd_ptr, rd_ptr_n;
  logic [LW-1:0] level_n;
  logic [7:0]    head_n;

  always_comb begin
    wr_ptr_1 = wr_ptr + 1'b1;
    rd_ptr_n = rd_en ? rd_ptr + 1'b1 : rd_ptr;
    level_n  = level + (wr_en ? LW'(2) : LW'(0)) - (rd_en ? LW'(1) : LW'(0));
    // Writes need two free slots, so the new head can only collide with lane 0 when the queue empties.
    if (wr_en && (rd_ptr_n == wr_ptr)) head_n = wr_data0;
    else                               head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr]   <= wr_data0;
      mem[wr_ptr_1] <= wr_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(2);
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      head   <= head_n;
    end
  end

endmodule

// File: rtl/entropy_tx_buffer.sv
// rtl/entropy_tx_buffer.sv - Splits random words into bytes and feeds them to the UART under its busy handshake.
// Build option ENTROPY_TX_BUFFER_HEALTH_EN adds the repetition-count health test.
module entropy_tx_buffer
  import entropy_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int REP_LIMIT  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        word_valid,
  input  logic [15:0]                 word,
  input  logic                        tx_busy,
  output logic                        tx_start,
  output logic [7:0]                  tx_byte,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        health_fail
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e  state, state_n;
  logic [1:0] guard_cnt, guard_n;
  logic [7:0] head, tx_byte_q;
  logic       has_space, push_ok, drop_full, overflow_q;

  assign has_space = fifo_level <= LW'(FIFO_DEPTH - 2);
  assign push_ok   = word_valid && has_space && !health_fail;
  assign drop_full = word_valid && !has_space && !health_fail;

  byte_fifo_2w1r #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push_ok),
    .wr_data0 (word[7:0]),
    .wr_data1 (word[15:8]),
    .rd_en    (tx_start),
    .head     (head),
    .level    (fifo_level)
  );

  always_comb begin
    state_n  = state;
    guard_n  = guard_cnt;
    tx_start = 1'b0;
    case (state)
      IDLE: begin
        if ((fifo_level != '0) && !tx_busy && !rst) begin
          tx_start = 1'b1;
          guard_n  = '0;
          state_n  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy)                              state_n = WAIT_DONE;
        else if (guard_cnt == 2'(BUSY_GUARD - 1)) state_n = IDLE;
        else                                      guard_n = guard_cnt + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      guard_cnt  <= '0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state     <= state_n;
      guard_cnt <= guard_n;
      if (tx_start)  tx_byte_q  <= head;
      if (drop_full) overflow_q <= 1'b1;
    end
  end

  // The UART samples the byte with the start strobe, so the head is presented in that same cycle.
  assign tx_byte  = tx_start ? head : tx_byte_q;
  assign overflow = overflow_q;

`ifdef ENTROPY_TX_BUFFER_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 3);

  logic [7:0]    last_byte;
  logic [RW-1:0] run_cnt, run_lo, run_hi;
  logic          health_q;

  always_comb begin
    run_lo = (word[7:0] == last_byte)   ? run_cnt + 1'b1 : RW'(1);
    run_hi = (word[15:8] == word[7:0])  ? run_lo + 1'b1  : RW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_byte <= '0;
      run_cnt   <= '0;
      health_q  <= 1'b0;
    end else if (push_ok) begin
      last_byte <= word[15:8];
      run_cnt   <= (run_hi > RW'(REP_LIMIT)) ? RW'(REP_LIMIT) : run_hi;
      if ((run_lo >= RW'(REP_LIMIT)) || (run_hi >= RW'(REP_LIMIT))) health_q <= 1'b1;
    end
  end

  assign health_fail = health_q;
`else
  // Zero for every legal REP_LIMIT; no comparator or counter exists in this build.
  assign health_fail = (REP_LIMIT < 2);
`endif

endmodule
